// File: rtl/pad_ctrl_pkg.sv
// Shared types and constants for the bidirectional pad controller.
package pad_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IN,
    S_TURN,
    S_OUT
  } pad_dir_state_e;

  localparam int unsigned ATTR_PE_BIT = 0;

endpackage

// File: rtl/pad_in_filter.sv
// Pad receive path: 2-flop synchronizer, length-programmable glitch filter and
// registered rise/fall event pulses.
module pad_in_filter
  import pad_ctrl_pkg::*;
#(
  parameter int unsigned FILT_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pad_out_i,
  input  logic [FILT_W-1:0] filt_len_i,
  output logic              in_val_o,
  output logic              rise_o,
  output logic              fall_o
);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [FILT_W-1:0] cnt_q, cnt_d;
  logic              val_q, val_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    sync1_d = pad_out_i;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q == val_q) begin
      cnt_d = '0;
    end else if (cnt_q >= filt_len_i) begin
      // >= so that lowering the length mid-count commits at once
      val_d  = sync2_q;
      cnt_d  = '0;
      rise_d = sync2_q;
      fall_d = ~sync2_q;
    end else if (cnt_q != {FILT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      val_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign in_val_o = val_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/pad_ctrl_inout.sv
// Core-side controller for one bidirectional pad: receive filter plus a direction
// FSM that inserts a dead time before the pad is driven.
module pad_ctrl_inout
  import pad_ctrl_pkg::*;
#(
  parameter int unsigned PADATTR = 16,
  parameter int unsigned FILT_W  = 4,
  parameter int unsigned TURN_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               out_val_i,
  input  logic               out_en_i,
  input  logic [PADATTR-1:0] attr_i,
  input  logic [FILT_W-1:0]  filt_len_i,
  input  logic [TURN_W-1:0]  turn_cycles_i,
  output logic               in_val_o,
  output logic               rise_o,
  output logic               fall_o,
  output logic               dir_busy_o,
  output logic               pad_in_o,
  output logic               pad_oe_o,
  input  logic               pad_out_i,
  output logic [PADATTR-1:0] pad_attributes_o
);

  pad_dir_state_e     state_q, state_d;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic               oe_q, oe_d;
  logic               busy_q, busy_d;
  logic               pad_in_q, pad_in_d;
  logic [PADATTR-1:0] attr_q, attr_d;

  pad_in_filter #(
    .FILT_W(FILT_W)
  ) u_in_filter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .pad_out_i (pad_out_i),
    .filt_len_i(filt_len_i),
    .in_val_o  (in_val_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o)
  );

  always_comb begin
    state_d  = state_q;
    turn_d   = turn_q;
    pad_in_d = out_val_i;
    attr_d   = attr_i;
    unique case (state_q)
      S_IN: begin
        if (out_en_i) begin
          if (turn_cycles_i == '0) begin
            state_d = S_OUT;
          end else begin
            state_d = S_TURN;
            turn_d  = turn_cycles_i;
          end
        end
      end
      S_TURN: begin
        if (!out_en_i) begin
          state_d = S_IN;
        end else if (turn_q <= TURN_W'(1)) begin
          state_d = S_OUT;
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end
      S_OUT: begin
        if (!out_en_i) begin
          state_d = S_IN;
        end
      end
      default: state_d = S_IN;
    endcase
    // Outputs decoded from the next state so they are registered with it
    oe_d   = (state_d == S_OUT);
    busy_d = (state_d == S_TURN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IN;
      turn_q   <= '0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      pad_in_q <= 1'b0;
      attr_q   <= '0;
    end else begin
      state_q  <= state_d;
      turn_q   <= turn_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      pad_in_q <= pad_in_d;
      attr_q   <= attr_d;
    end
  end

  assign pad_oe_o         = oe_q;
  assign dir_busy_o       = busy_q;
  assign pad_in_o         = pad_in_q;
  assign pad_attributes_o = attr_q;

endmodule
